fetch_unit: RTL and testbench

- Parametrised instruction-fetch front end for the MIPS core. Replaces the single-register PC with a decoupled PC generator, in-order instruction-memory request path and prefetch queue.
- Delivers {instruction, PC, PC+4} to decode through a valid/ready handshake.
- Accepts branch/jump/jr redirects from execute, flushing queued and in-flight fetches.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 68 ++++++
 rtl/fetch_unit.sv | 149 ++++++++++++++
 tb/tb_fetch_unit.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction-fetch front end.
package fetch_pkg;

    localparam int FETCH_ADDR_W = 32;
    localparam int INS_W        = 32;

    localparam logic [FETCH_ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0040_0000;

    // Instructions are word aligned: the low ALIGN_BITS of any PC are zero.
    localparam int                      ALIGN_BITS      = 2;
    localparam logic [FETCH_ADDR_W-1:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

    typedef struct packed {
        logic [INS_W-1:0]        ins;
        logic [FETCH_ADDR_W-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; used both for request PC tags and the prefetch queue.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_push;
    logic w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_pop  = i_pop & ~o_empty;
    assign w_push = i_push & (~o_full | w_pop);

    always_ff @(posedge clock) begin
        if (w_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Decoupled fetch front end: PC generator, in-order memory request path with
// PC tagging, and a prefetch queue feeding decode over valid/ready.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = FETCH_ADDR_W,
    parameter int                DATA_W   = INS_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT),
    parameter int                DEPTH    = 4
) (
    input  logic              clock,
    input  logic              reset,
    output logic              imem_req_out,
    output logic [ADDR_W-1:0] imem_addr_out,
    input  logic              imem_gnt_in,
    input  logic [DATA_W-1:0] imem_rdata_in,
    input  logic              imem_rvalid_in,
    input  logic              redirect_in,
    input  logic [ADDR_W-1:0] redirect_pc_in,
    output logic [DATA_W-1:0] ins_out,
    output logic [ADDR_W-1:0] ins_pc_out,
    output logic [ADDR_W-1:0] pcn_out,
    output logic              valid_out,
    input  logic              ready_in
);

    localparam int                CNT_W      = $clog2(DEPTH) + 1;
    localparam int                Q_W        = DATA_W + ADDR_W;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'((1 << ALIGN_BITS) - 1);

    logic [ADDR_W-1:0] r_fetch_pc;
    logic [CNT_W-1:0]  r_discard;
    logic [DATA_W-1:0] r_ins_hold;
    logic [ADDR_W-1:0] r_pc_hold;
    logic [ADDR_W-1:0] r_pcn_hold;

    logic [CNT_W-1:0]  w_q_count;
    logic [CNT_W-1:0]  w_tag_count;
    logic              w_q_full;
    logic              w_q_empty;
    logic              w_tag_full;
    logic              w_tag_empty;
    logic [ADDR_W-1:0] w_tag_head;
    logic [Q_W-1:0]    w_q_head;
    logic [DATA_W-1:0] w_head_ins;
    logic [ADDR_W-1:0] w_head_pc;
    logic [ADDR_W-1:0] w_head_pcn;
    logic [CNT_W:0]    w_in_use;
    logic              w_credit;
    logic              w_grant;
    logic              w_rsp;
    logic              w_keep;
    logic              w_pop;
    logic [CNT_W-1:0]  w_discard_next;

    // Every accepted request reserves a queue slot, so responses never overflow.
    assign w_in_use = {1'b0, w_q_count} + {1'b0, w_tag_count};
    assign w_credit = ~w_q_full & ~w_tag_full & (w_in_use < (CNT_W+1)'(DEPTH));

    // reset is active-low; requests are held off while it is asserted.
    assign imem_req_out  = reset & ~redirect_in & w_credit;
    assign imem_addr_out = r_fetch_pc;
    assign w_grant       = imem_req_out & imem_gnt_in;

    // A response with no tag outstanding (e.g. left over across a reset) is ignored.
    assign w_rsp  = imem_rvalid_in & ~w_tag_empty;
    assign w_keep = w_rsp & (r_discard == '0) & ~redirect_in;
    assign w_pop  = valid_out & ready_in;

    fetch_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_flush (1'b0),
        .i_push  (w_grant),
        .i_data  (r_fetch_pc),
        .i_pop   (w_rsp),
        .o_data  (w_tag_head),
        .o_count (w_tag_count),
        .o_full  (w_tag_full),
        .o_empty (w_tag_empty)
    );

    fetch_fifo #(
        .WIDTH (Q_W),
        .DEPTH (DEPTH)
    ) u_prefetch_q (
        .clock   (clock),
        .reset   (reset),
        .i_flush (redirect_in),
        .i_push  (w_keep),
        .i_data  ({imem_rdata_in, w_tag_head}),
        .i_pop   (w_pop),
        .o_data  (w_q_head),
        .o_count (w_q_count),
        .o_full  (w_q_full),
        .o_empty (w_q_empty)
    );

    assign w_head_ins = w_q_head[Q_W-1:ADDR_W];
    assign w_head_pc  = w_q_head[ADDR_W-1:0];
    assign w_head_pcn = w_head_pc + ADDR_W'(4);

    always_comb begin
        w_discard_next = r_discard;
        if (redirect_in) begin
            // Everything still in flight belongs to the old stream, including
            // a response landing this cycle (already popped from the tags).
            w_discard_next = w_tag_count - CNT_W'(w_rsp) + CNT_W'(w_grant);
        end else if (w_rsp && (r_discard != '0)) begin
            w_discard_next = r_discard - CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_fetch_pc <= RESET_PC;
            r_discard  <= '0;
        end else begin
            r_discard <= w_discard_next;
            if (redirect_in) begin
                r_fetch_pc <= redirect_pc_in & ALIGN_MASK;
            end else if (w_grant) begin
                r_fetch_pc <= r_fetch_pc + ADDR_W'(4);
            end
        end
    end

    // Decode-facing fields keep showing the last head once the queue empties.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ins_hold <= '0;
            r_pc_hold  <= '0;
            r_pcn_hold <= '0;
        end else if (!w_q_empty) begin
            r_ins_hold <= w_head_ins;
            r_pc_hold  <= w_head_pc;
            r_pcn_hold <= w_head_pcn;
        end
    end

    assign valid_out  = ~w_q_empty;
    assign ins_out    = w_q_empty ? r_ins_hold : w_head_ins;
    assign ins_pc_out = w_q_empty ? r_pc_hold  : w_head_pc;
    assign pcn_out    = w_q_empty ? r_pcn_hold : w_head_pcn;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: an in-order memory model with random
// latency, and a PC-stream reference model segmented by redirects.
`timescale 1ns/1ps
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int          ADDR_W = 32;
    localparam int          DATA_W = 32;
    localparam int          DEPTH  = 4;
    localparam logic [31:0] RPC    = RESET_PC_DEFAULT;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              imem_req_out;
    logic [ADDR_W-1:0] imem_addr_out;
    logic              imem_gnt_in = 1'b0;
    logic [DATA_W-1:0] imem_rdata_in = '0;
    logic              imem_rvalid_in = 1'b0;
    logic              redirect_in = 1'b0;
    logic [ADDR_W-1:0] redirect_pc_in = '0;
    logic [DATA_W-1:0] ins_out;
    logic [ADDR_W-1:0] ins_pc_out;
    logic [ADDR_W-1:0] pcn_out;
    logic              valid_out;
    logic              ready_in = 1'b0;

    always #5 clock = ~clock;

    fetch_unit #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .RESET_PC (RPC),
        .DEPTH    (DEPTH)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .imem_req_out   (imem_req_out),
        .imem_addr_out  (imem_addr_out),
        .imem_gnt_in    (imem_gnt_in),
        .imem_rdata_in  (imem_rdata_in),
        .imem_rvalid_in (imem_rvalid_in),
        .redirect_in    (redirect_in),
        .redirect_pc_in (redirect_pc_in),
        .ins_out        (ins_out),
        .ins_pc_out     (ins_pc_out),
        .pcn_out        (pcn_out),
        .valid_out      (valid_out),
        .ready_in       (ready_in)
    );

    typedef struct { fetch_entry_t e; int epoch; } exp_t;
    typedef struct { logic [31:0] addr; int due; } rsp_t;

    exp_t exp_q[$];
    rsp_t pend[$];

    int total = 0;
    int bad   = 0;
    int cyc = 0, epoch = 0, last_due = 0, tb_out = 0, grants = 0;
    int lat_lo = 1, lat_hi = 1, gnt_pct = 100;
    logic [31:0] model_pc = RPC;
    logic [31:0] req_pc_model = RPC;
    bit s_req, s_valid;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock cycle: entered at posedge+1, drives inputs, samples at negedge.
    task automatic step(input bit do_redir, input logic [31:0] tgt, input bit rdy);
        exp_t n;
        rsp_t r;
        int   lat;
        bit   g;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            r = pend.pop_front();
            imem_rvalid_in = 1'b1;
            imem_rdata_in  = mem_data(r.addr);
            tb_out--;
        end else begin
            imem_rvalid_in = 1'b0;
            imem_rdata_in  = $urandom;
        end
        g              = ($urandom_range(99) < gnt_pct);
        imem_gnt_in    = g;
        ready_in       = rdy;
        redirect_in    = do_redir;
        redirect_pc_in = tgt;
        if (do_redir) begin
            epoch++;
            model_pc     = tgt & WORD_ALIGN_MASK;
            req_pc_model = tgt & WORD_ALIGN_MASK;
        end
        if (exp_q.size() < 32) begin
            n.e.ins = mem_data(model_pc);
            n.e.pc  = model_pc;
            n.epoch = epoch;
            exp_q.push_back(n);
            model_pc += 32'd4;
        end
        @(negedge clock);
        s_req   = imem_req_out;
        s_valid = valid_out;
        if (do_redir) check("req_in_redirect", {31'd0, imem_req_out}, 32'd0);
        if (imem_req_out && g) begin
            check("req_addr", imem_addr_out, req_pc_model);
            req_pc_model += 32'd4;
            lat    = $urandom_range(lat_hi, lat_lo);
            r.addr = imem_addr_out;
            r.due  = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
            last_due = r.due;
            pend.push_back(r);
            tb_out++;
            grants++;
        end
        total++;
        if (tb_out > DEPTH) begin
            bad++;
            $display("FAIL credit: outstanding %0d exceeds %0d", tb_out, DEPTH);
        end
        @(posedge clock);
        cyc++;
        #1;
    endtask

    task automatic run(input int n, input int rdy_pct);
        for (int i = 0; i < n; i++) step(1'b0, 32'd0, $urandom_range(99) < rdy_pct);
    endtask

    // Entered at posedge+1; asserts reset between edges and releases just after an edge.
    task automatic do_reset(input bit check_clear);
        #2;
        reset = 1'b0;
        #1;
        if (check_clear) begin
            check("rst_req",   {31'd0, imem_req_out}, 32'd0);
            check("rst_valid", {31'd0, valid_out}, 32'd0);
            check("rst_ins",   ins_out, 32'd0);
            check("rst_pc",    ins_pc_out, 32'd0);
            check("rst_pcn",   pcn_out, 32'd0);
        end
        redirect_in = 1'b0; imem_rvalid_in = 1'b0; imem_gnt_in = 1'b0; ready_in = 1'b0;
        pend.delete();
        exp_q.delete();
        tb_out = 0; last_due = cyc; grants = 0;
        epoch++;
        model_pc = RPC; req_pc_model = RPC;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    // Monitor: pops the expected head whenever decode consumes one.
    initial begin
        exp_t x;
        forever begin
            @(negedge clock);
            if (reset && valid_out && ready_in) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_empty: got pc %h, expected no delivery", ins_pc_out);
                end else begin
                    x = exp_q.pop_front();
                    check("head_pc",  ins_pc_out, x.e.pc);
                    check("head_ins", ins_out, x.e.ins);
                    check("head_pcn", pcn_out, x.e.pc + 32'd4);
                    $display("deliver pc=%h ins=%h", ins_pc_out, ins_out);
                end
            end
            if (reset && redirect_in) begin
                while (exp_q.size() > 0 && exp_q[0].epoch < epoch) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        @(posedge clock);
        #1;
        do_reset(1'b1);

        // 1-cycle memory, decode always ready: valid two cycles after release.
        lat_lo = 1; lat_hi = 1; gnt_pct = 100;
        step(1'b0, 32'd0, 1'b1); check("valid_c1", {31'd0, s_valid}, 32'd0);
        step(1'b0, 32'd0, 1'b1); check("valid_c2", {31'd0, s_valid}, 32'd0);
        step(1'b0, 32'd0, 1'b1); check("valid_c3", {31'd0, s_valid}, 32'd1);
        run(20, 100);

        // Mid-stream reset, then decode stalled: only DEPTH requests may issue.
        do_reset(1'b1);
        run(10, 0);
        check("grants_stalled", grants, DEPTH);
        check("req_stalled", {31'd0, s_req}, 32'd0);
        run(20, 100);

        // Redirect with several fetches in flight on a 3-cycle memory.
        lat_lo = 3; lat_hi = 3;
        run(10, 100);
        step(1'b1, 32'h0040_0100, 1'b1);
        run(15, 100);

        // Unaligned target during a 1-cycle stream (rvalid coincides with redirect).
        lat_lo = 1; lat_hi = 1;
        run(8, 100);
        step(1'b1, 32'h0040_0203, 1'b1);
        step(1'b0, 32'd0, 1'b1);
        check("req_after_redirect", {31'd0, s_req}, 32'd1);
        run(10, 100);

        // Back-to-back redirects: the later target wins.
        lat_lo = 2; lat_hi = 4;
        run(6, 100);
        step(1'b1, 32'h0040_0800, 1'b1);
        step(1'b1, 32'h0040_0A00, 1'b0);
        run(15, 100);

        // Randomised traffic.
        lat_lo = 1; lat_hi = 5; gnt_pct = 60;
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(99) < 3, 32'h0040_0000 + 32'($urandom_range(0, 1023)),
                 $urandom_range(99) < 70);
        end

        lat_lo = 1; lat_hi = 1; gnt_pct = 100;
        run(30, 100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
